pc_unit: RTL and testbench

//  Parametrised program-counter unit for the MIPS fetch stage. Holds the current PC and selects the next one.

---
 rtl/pc_unit.sv | 136 +++++++++++++
 tb/tb_pc_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: holds the PC and picks the next
// one from sequential, branch, jump, RAS return, exception and eret sources.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   stall_i          hold PC (exceptions and eret still go through)
//   branch_taken_i   redirect to branch_target_i
//   jump_i           redirect to jump_target_i
//   call_i           push pc_plus4_o onto the return-address stack
//   ret_i            pop the RAS and redirect (jump_target_i if it is empty)
//   exc_i / eret_i   enter the exception vector / return to epc_o
//   pc_o, pc_plus4_o current PC and PC + 4
//   epc_o            saved exception PC
//   ras_empty_o      return-address stack is empty
//   ras_full_o       return-address stack is full
//   misalign_o       the last accepted target had nonzero low bits
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            exc_i,
    input  logic            eret_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] epc_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            misalign_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [PW-1:0]   ptr_q, ptr_d, ptr_pop, wr_idx;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_pop;
    logic            mis_q, mis_d;
    logic            push, pop, redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_q + XLEN'(4);
    assign epc_o       = epc_q;
    assign ras_empty_o = (cnt_q == '0);
    assign ras_full_o  = (cnt_q == FULL_CNT);
    assign misalign_o  = mis_q;

    // Next-PC selection; RAS traffic only happens when the PC
    // actually advances or redirects (not on stall/exc/eret).
    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        mis_d    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        redirect = 1'b0;
        target   = '0;
        if (exc_i) begin
            epc_d = pc_q;
            pc_d  = EXC_VECTOR;
        end else if (eret_i) begin
            pc_d = epc_q;
        end else if (!stall_i) begin
            push = call_i;
            pop  = ret_i && !ras_empty_o;
            if (ret_i) begin
                redirect = 1'b1;
                target   = ras_empty_o ? jump_target_i : ras_mem[ptr_q];
            end else if (jump_i) begin
                redirect = 1'b1;
                target   = jump_target_i;
            end else if (branch_taken_i) begin
                redirect = 1'b1;
                target   = branch_target_i;
            end
            if (redirect) begin
                pc_d  = {target[XLEN-1:2], 2'b00};
                mis_d = |target[1:0];
            end else begin
                pc_d = pc_plus4_o;
            end
        end
    end

    // Pop is applied before push so call+ret replaces the top entry.
    // A push onto a full stack wraps over the oldest entry.
    always_comb begin
        ptr_pop = pop ? ptr_q - 1'b1 : ptr_q;
        cnt_pop = pop ? cnt_q - 1'b1 : cnt_q;
        wr_idx  = ptr_pop + 1'b1;
        ptr_d   = ptr_pop;
        cnt_d   = cnt_pop;
        if (push) begin
            ptr_d = wr_idx;
            if (cnt_pop != FULL_CNT)
                cnt_d = cnt_pop + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
        end
    end

    // Stack storage needs no reset: the count alone decides validity.
    always_ff @(posedge clk) begin
        if (!rst && push)
            ras_mem[wr_idx] <= pc_plus4_o;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with literal checks, then random
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_pc_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] EXC = 32'h8000_0180;
    localparam int          DEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, branch_taken_i, jump_i, call_i, ret_i;
    logic        exc_i, eret_i;
    logic [31:0] branch_target_i, jump_target_i;
    logic [31:0] pc_o, pc_plus4_o, epc_o;
    logic        ras_empty_o, ras_full_o, misalign_o;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [31:0] m_pc = '0;
    logic [31:0] m_epc = '0;
    logic        m_mis = 1'b0;
    logic [31:0] m_ras[$];

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .EXC_VECTOR(EXC), .RAS_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .call_i(call_i), .ret_i(ret_i), .exc_i(exc_i), .eret_i(eret_i),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .epc_o(epc_o),
        .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: PC/EPC as plain values, the RAS as a bounded queue.
    always @(posedge clk) begin
        logic [31:0] tgt;
        logic [31:0] ra;
        bit          have;
        if (rst) begin
            m_pc  = RV;
            m_epc = '0;
            m_mis = 1'b0;
            m_ras.delete();
        end else begin
            m_mis = 1'b0;
            if (exc_i) begin
                m_epc = m_pc;
                m_pc  = EXC;
            end else if (eret_i) begin
                m_pc = m_epc;
            end else if (!stall_i) begin
                ra   = m_pc + 32'd4;
                have = 1'b1;
                tgt  = '0;
                if (ret_i) begin
                    if (m_ras.size() > 0) tgt = m_ras.pop_back();
                    else tgt = jump_target_i;
                end else if (jump_i) tgt = jump_target_i;
                else if (branch_taken_i) tgt = branch_target_i;
                else have = 1'b0;
                if (call_i) begin
                    m_ras.push_back(ra);
                    if (m_ras.size() > DEP) void'(m_ras.pop_front());
                end
                if (have) begin
                    m_pc  = tgt & ~32'd3;
                    m_mis = (tgt % 4) != 0;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("pc", pc_o, m_pc);
            chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
            chk("epc", epc_o, m_epc);
            chk("ras_empty", 32'(ras_empty_o), 32'(m_ras.size() == 0));
            chk("ras_full", 32'(ras_full_o), 32'(m_ras.size() == DEP));
            chk("misalign", 32'(misalign_o), 32'(m_mis));
        end
    end

    task automatic idle();
        stall_i = 0; branch_taken_i = 0; jump_i = 0; call_i = 0;
        ret_i = 0; exc_i = 0; eret_i = 0;
        branch_target_i = '0; jump_target_i = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic jmp(input logic [31:0] t);
        idle(); jump_i = 1; jump_target_i = t; tick(); idle();
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        check_en = 1'b1;
        tick();
        chk("t1 reset pc", pc_o, 32'h0);
        chk("t1 reset empty", 32'(ras_empty_o), 32'd1);
        chk("t1 reset epc", epc_o, 32'h0);
        rst = 0;
        tick(); chk("t1 pc4", pc_o, 32'h4);
        tick(); chk("t1 pc8", pc_o, 32'h8);
        tick(); chk("t1 pcC", pc_o, 32'hC);
        tick(); chk("t1 pc10", pc_o, 32'h10);

        stall_i = 1; jump_i = 1; jump_target_i = 32'h40;
        repeat (3) begin tick(); chk("t2 hold", pc_o, 32'h10); end
        stall_i = 0; tick(); chk("t2 jump", pc_o, 32'h40);
        idle();

        jmp(32'h100);
        call_i = 1; jump_i = 1; jump_target_i = 32'h200; tick();
        chk("t3 call", pc_o, 32'h200);
        chk("t3 nonempty", 32'(ras_empty_o), 32'd0);
        idle(); ret_i = 1; tick();
        chk("t3 ret", pc_o, 32'h104);
        chk("t3 empty", 32'(ras_empty_o), 32'd1);
        idle();

        for (int i = 1; i <= 5; i++) begin
            call_i = 1; jump_i = 1; jump_target_i = 32'(i) << 12; tick();
        end
        chk("t4 full", 32'(ras_full_o), 32'd1);
        idle(); ret_i = 1; jump_target_i = 32'h7770;
        tick(); chk("t4 ret1", pc_o, 32'h4004);
        tick(); chk("t4 ret2", pc_o, 32'h3004);
        tick(); chk("t4 ret3", pc_o, 32'h2004);
        tick(); chk("t4 ret4", pc_o, 32'h1004);
        tick(); chk("t4 ret5", pc_o, 32'h7770);
        chk("t4 empty", 32'(ras_empty_o), 32'd1);
        idle();

        jmp(32'h30);
        exc_i = 1; stall_i = 1; tick();
        chk("t5 exc pc", pc_o, 32'h8000_0180);
        chk("t5 epc", epc_o, 32'h30);
        idle(); eret_i = 1; tick();
        chk("t5 eret", pc_o, 32'h30);
        idle();

        branch_taken_i = 1; branch_target_i = 32'h47; tick();
        chk("t6 align", pc_o, 32'h44);
        chk("t6 mis", 32'(misalign_o), 32'd1);
        idle(); tick();
        chk("t6 mis off", 32'(misalign_o), 32'd0);

        jmp(32'hFFFF_FFFC);
        tick(); chk("wrap", pc_o, 32'h0);

        call_i = 1; tick(); tick(); idle();
        rst = 1; tick(); rst = 0;
        chk("t6 rst empty", 32'(ras_empty_o), 32'd1);
        chk("t6 rst pc", pc_o, RV);

        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 199) == 0);
            stall_i         = ($urandom_range(0, 4) == 0);
            branch_taken_i  = ($urandom_range(0, 3) == 0);
            jump_i          = ($urandom_range(0, 4) == 0);
            call_i          = ($urandom_range(0, 3) == 0);
            ret_i           = ($urandom_range(0, 3) == 0);
            exc_i           = ($urandom_range(0, 29) == 0);
            eret_i          = ($urandom_range(0, 24) == 0);
            branch_target_i = $urandom;
            jump_target_i   = $urandom;
            tick();
        end
        rst = 0;
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
